buffer_write_arbiter: RTL
=========================

Name: buffer_write_arbiter

Overview:
Round-robin write arbiter that shares one circular byte buffer among NUM_REQ producers. Each producer uses a valid/ready handshake. A granted producer keeps the buffer for a burst of up to MAX_BURST beats. The arbiter drives the buffer's write port and honours its full flag. It sits directly in front of the circular buffer's write_enable/write_data/full pins; the read side is untouched.

Parameters:
NUM_REQ, 4, number of producers; legal range 2..8.
MAX_BURST, 4, maximum accepted beats per grant; must be >= 1.
DATA_WIDTH, 8, beat width; must equal the buffer data width.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
req_valid  in  NUM_REQ  per-producer data valid.
req_data  in  NUM_REQ*DATA_WIDTH  packed data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  out  NUM_REQ  per-producer accept strobe; at most one bit high per cycle.
buf_full  in  1  full flag from the circular buffer.
buf_write_enable  out  1  write strobe to the buffer.
buf_write_data  out  DATA_WIDTH  write data to the buffer.
grant_id  out  $clog2(NUM_REQ)  current owner; meaningful only while busy=1.
busy  out  1  high while in state BURST.
total_writes  out  16  count of accepted beats; wraps at 65535->0.

Behaviour:
- Reset (rst_n low at a posedge) sets: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, total_writes=0.
- While rst_n is low, buf_write_enable and req_ready are forced to 0 combinationally. A reset mid-burst therefore aborts with no write in that cycle.
- IDLE state:
  - req_ready=0, buf_write_enable=0, busy=0.
  - Winner = first asserted req_valid, searching from rr_ptr upward with modulo-NUM_REQ wrap.
  - If a winner exists: owner<=winner, burst_cnt<=0, state<=BURST.
  - Otherwise stay in IDLE.
  - Arbitration costs one cycle, so peak throughput is MAX_BURST/(MAX_BURST+1).
- BURST state:
  - beat = req_valid[owner] && !buf_full && rst_n.
  - buf_write_enable = beat; req_ready[owner] = beat; all other req_ready bits are 0.
  - buf_write_data = req_data[owner] at all times in BURST; it is 0 in IDLE.
  - On each beat: burst_cnt++, total_writes++.
  - buf_full=1 with valid=1 is a stall: no beat, burst_cnt holds, state holds. There is no timeout.
  - Exit to IDLE in either case:
    - a beat occurs with burst_cnt==MAX_BURST-1; or
    - req_valid[owner]==0 in that cycle (no beat).
  - On exit, rr_ptr<=(owner+1) mod NUM_REQ.
- Fairness: a producer holding valid high is granted within NUM_REQ-1 other bursts.
- MAX_BURST=1 gives single-beat grants that alternate with IDLE.
- Requests not granted are ignored and never acknowledged. Producers must hold data stable until their req_ready is seen.
- The full flag is treated as already reflecting the buffer state for this cycle. The arbiter never asserts buf_write_enable while buf_full=1.
- All state is registered. Outputs are combinational from state, owner, req_valid, req_data and buf_full; there is no path from req_valid to any state change within the same cycle.

Decomposition:
- Package buffer_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  - localparam TOTAL_W=16.
- One sub-module, rr_pick: a combinational rotating-priority encoder.
  - Inputs: req[NUM_REQ], base[$clog2(NUM_REQ)].
  - Outputs: any, idx.
- Burst counter, owner register and total counter live in the top module.

Test Plan:
1. Reset, then req_valid=4'b0001, buf_full=0, data 0x11..0x14 -> IDLE for 1 cycle, then 4 consecutive beats 0x11..0x14 with grant_id=0; then IDLE; total_writes=4; rr_ptr=1.
2. All four producers valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0; each burst exactly 4 beats; each burst separated by one idle cycle; total_writes=16 after four bursts.
3. Producer 2 alone, buf_full raised for 3 cycles after its 2nd beat -> buf_write_enable=0 and req_ready=0 during the stall; burst_cnt holds at 2; 2 more beats after full drops; then exit.
4. Producer 1 drops valid after 1 beat while producer 3 is waiting -> arbiter returns to IDLE next cycle; producer 3 granted; rr_ptr goes 2 then 0.
5. rst_n pulled low mid-burst after beat 2 -> no write that cycle; all outputs 0 next cycle; total_writes=0; rr_ptr=0; a fresh request from producer 0 is granted first.
6. total_writes preset by running 65535 beats, then one more beat -> total_writes wraps to 0.

Source files
------------

// File: rtl/buffer_arb_pkg.sv
// Shared types for the buffer write arbiter.
// Arbiter FSM state encoding and counter width.
package buffer_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int TOTAL_W = 16;

endpackage

// File: rtl/buffer_write_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request
// at or above base, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   base,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W:0]       sum;

  always_comb begin
    dbl = {req, req} >> base;
    rot = dbl[NUM_REQ-1:0];
    any = 1'b0;
    idx = '0;
    sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        sum = {1'b0, base} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(NUM_REQ))
          sum = sum - (IDX_W+1)'(NUM_REQ);
        idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin burst arbiter in front of the
// circular buffer write port.
module buffer_write_arbiter
  import buffer_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BURST  = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(MAX_BURST+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          buf_full,
  output logic                          buf_write_enable,
  output logic [DATA_WIDTH-1:0]         buf_write_data,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic [TOTAL_W-1:0]            total_writes
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             own_valid;
  logic             beat;
  logic             last;
  logic [IDX_W-1:0] next_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req_valid),
    .base (rr_ptr_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    busy      = (state_q == ARB_BURST);
    own_valid = req_valid[owner_q];
    // rst_n gates the strobe so a reset aborts the beat
    beat      = busy && own_valid && !buf_full && rst_n;
    last      = (burst_cnt_q == CNT_W'(MAX_BURST-1));
    next_ptr  = (owner_q == IDX_W'(NUM_REQ-1))
              ? '0 : owner_q + 1'b1;

    req_ready = '0;
    if (beat)
      req_ready[owner_q] = 1'b1;
    buf_write_enable = beat;
    buf_write_data   = busy
      ? req_data[owner_q*DATA_WIDTH +: DATA_WIDTH]
      : '0;
    grant_id     = owner_q;
    total_writes = total_q;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    total_d     = total_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (beat) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          total_d     = total_q + 1'b1;
        end
        if ((beat && last) || !own_valid) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      total_q     <= total_d;
    end
  end

endmodule
